// File: rtl/btb_predictor.sv
// btb_predictor
//   Direct-mapped, tagged branch target buffer with 2-bit saturating direction
//   counters. Serves the fetch stage with a same-cycle next-PC prediction and
//   absorbs resolved-branch updates from the EX/MEM boundary. A resolved branch
//   whose direction or target disagrees with the prediction raises redirect and
//   supplies the correct next PC. The table is cleared after reset by a sweep
//   that clears one entry per cycle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   if_pc               PC being fetched
//   pred_hit/taken      lookup result at if_pc
//   pred_target         predicted next PC (stored target or if_pc+1)
//   upd_valid           a branch/jump resolves this cycle
//   upd_pc/kind/taken   resolving instruction, its kind and actual direction
//   upd_target          actual taken target
//   upd_pred_taken      prediction carried down the pipe (direction)
//   upd_pred_target     prediction carried down the pipe (target)
//   redirect            misprediction, flush younger stages
//   redirect_pc         correct next PC after the resolving instruction
//   ready               sweep complete, predictions valid
//   mispredict_count    number of redirects since reset (wrapping)
module btb_predictor #(
  parameter int PC_W    = 16,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    if_pc,
  output logic               pred_hit,
  output logic               pred_taken,
  output logic [PC_W-1:0]    pred_target,
  input  logic               upd_valid,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic [1:0]         upd_kind,
  input  logic               upd_taken,
  input  logic [PC_W-1:0]    upd_target,
  input  logic               upd_pred_taken,
  input  logic [PC_W-1:0]    upd_pred_target,
  output logic               redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               ready,
  output logic [CNT_W-1:0]   mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = PC_W - INDEX_W;

  localparam logic       ST_INIT = 1'b0;
  localparam logic       ST_RUN  = 1'b1;

  localparam logic [1:0] KIND_COND = 2'b00;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  // Control state
  logic                 state_q, state_d;
  logic [INDEX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // Table storage
  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [PC_W-1:0]      target_q [ENTRIES];
  logic [PC_W-1:0]      target_d [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [1:0]           ctr_d    [ENTRIES];

  // Lookup side
  logic [INDEX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_match;

  // Update side
  logic [INDEX_W-1:0]   u_idx;
  logic [TAG_W-1:0]     u_tag;
  logic                 u_hit;
  logic                 u_act;
  logic                 eff_taken;
  logic                 wr_en;
  logic [1:0]           wr_ctr;
  logic [PC_W-1:0]      wr_target;
  logic [1:0]           old_ctr;

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational from registered table contents
  // ---------------------------------------------------------------------------
  always_comb begin
    lk_idx      = if_pc[INDEX_W-1:0];
    lk_tag      = if_pc[PC_W-1:INDEX_W];
    lk_match    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_hit    = (state_q == ST_RUN) && lk_match;
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : (if_pc + PC_W'(1));
  end

  // ---------------------------------------------------------------------------
  // Resolution: redirect is evaluated in both INIT and RUN
  // ---------------------------------------------------------------------------
  always_comb begin
    u_act       = upd_valid && (upd_kind != KIND_RSVD);
    eff_taken   = (upd_kind == KIND_COND) ? upd_taken : 1'b1;
    redirect    = u_act && ((eff_taken != upd_pred_taken) ||
                            (eff_taken && (upd_target != upd_pred_target)));
    redirect_pc = eff_taken ? upd_target : (upd_pc + PC_W'(1));
  end

  // ---------------------------------------------------------------------------
  // Update entry computation (only committed in RUN)
  // ---------------------------------------------------------------------------
  always_comb begin
    u_idx     = upd_pc[INDEX_W-1:0];
    u_tag     = upd_pc[PC_W-1:INDEX_W];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    old_ctr   = ctr_q[u_idx];
    wr_en     = 1'b0;
    wr_ctr    = old_ctr;
    wr_target = target_q[u_idx];

    if (u_act && (state_q == ST_RUN)) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_kind == KIND_COND) begin
          if (upd_taken) begin
            wr_ctr    = (old_ctr == 2'b11) ? old_ctr : old_ctr + 2'b01;
            wr_target = upd_target;
          end else begin
            wr_ctr    = (old_ctr == 2'b00) ? old_ctr : old_ctr - 2'b01;
          end
        end else begin
          wr_ctr    = 2'b11;
          wr_target = upd_target;
        end
      end else if (eff_taken) begin
        // Allocation overwrites whatever lives at this index
        wr_en     = 1'b1;
        wr_ctr    = (upd_kind == KIND_COND) ? 2'b10 : 2'b11;
        wr_target = upd_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for control and table
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(redirect);

    if (state_q == ST_INIT) begin
      idx_d = idx_q + INDEX_W'(1);
      if (idx_q == INDEX_W'(ENTRIES - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (state_q == ST_INIT) begin
      valid_d[idx_q] = 1'b0;
    end else if (wr_en) begin
      valid_d[u_idx]  = 1'b1;
      tag_d[u_idx]    = u_tag;
      target_d[u_idx] = wr_target;
      ctr_d[u_idx]    = wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Table contents are not reset directly; the INIT sweep clears valid bits.
  // While reset is held the state is INIT with no update enabled, and the
  // sweep write only starts once reset is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign ready            = (state_q == ST_RUN);
  assign mispredict_count = cnt_q;

endmodule
